// File: rtl/dot_operand_loader.sv
// -----------------------------------------------------------------------------
// dot_operand_loader
//
// Purpose:
//   Upstream feeder for a dot-product stage. Operand pairs (a[i], b[i]) arrive
//   on a valid/ready stream and are assembled into two VECTOR_SIZE-element
//   register arrays. Once the last pair is accepted, start_dot is raised and
//   held until the dot stage reports done. dot_result is then captured and
//   offered on a valid/ready result port. Only one dot product is in flight.
//
//   Sequence: LOAD -> RUN -> OUT -> LOAD.
//
// Optional feature:
//   DOT_TIMEOUT_EN  - when defined, a cycle counter bounds the RUN phase to
//                     TIMEOUT_CYCLES. On expiry the job is aborted with a zero
//                     result and the sticky timeout_err flag is set. When
//                     undefined, RUN waits indefinitely and timeout_err is 0.
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous reset, active low
//   in_valid     in   operand pair valid
//   in_ready     out  loader can accept a pair (combinational: state == LOAD)
//   in_a, in_b   in   operand elements a[idx], b[idx]
//   a_vec, b_vec out  registered vectors to the dot stage
//   start_dot    out  level start to the dot stage
//   dot_result   in   dot stage result
//   dot_done     in   dot stage done (level)
//   res_valid    out  result available
//   res_ready    in   consumer accepts result
//   res_data     out  captured dot product (bit-exact pass-through)
//   busy         out  high unless in LOAD with idx == 0
//   timeout_err  out  sticky abort flag
// -----------------------------------------------------------------------------
module dot_operand_loader #(
    parameter int FRACTION_WIDTH = 15,
    parameter int BIT_WIDTH      = 32,
    parameter int VECTOR_SIZE    = 10,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [BIT_WIDTH-1:0]                  in_a,
    input  logic [BIT_WIDTH-1:0]                  in_b,
    output logic [VECTOR_SIZE-1:0][BIT_WIDTH-1:0] a_vec,
    output logic [VECTOR_SIZE-1:0][BIT_WIDTH-1:0] b_vec,
    output logic                                  start_dot,
    input  logic [BIT_WIDTH-1:0]                  dot_result,
    input  logic                                  dot_done,
    output logic                                  res_valid,
    input  logic                                  res_ready,
    output logic [BIT_WIDTH-1:0]                  res_data,
    output logic                                  busy,
    output logic                                  timeout_err
);

    localparam int IDX_W = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VECTOR_SIZE - 1);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 armed_q, armed_d;
    logic                 start_q, start_d;
    logic                 res_valid_q, res_valid_d;
    logic [BIT_WIDTH-1:0] res_data_q, res_data_d;
    logic                 busy_q, busy_d;
    logic                 load_en;

    // The fixed-point format is only carried through; no arithmetic uses it.
    logic unused_fraction_cfg;
    assign unused_fraction_cfg = (FRACTION_WIDTH != 0);

`ifdef DOT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             terr_q, terr_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    // -------------------------------------------------------------------------
    // Control next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        armed_d     = armed_q;
        start_d     = start_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        load_en     = 1'b0;
`ifdef DOT_TIMEOUT_EN
        cnt_d       = cnt_q;
        terr_d      = terr_q;
`endif

        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    load_en = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_RUN;
                        start_d = 1'b1;
                        // Arming starts fresh so a done left high from the
                        // previous job cannot complete this one.
                        armed_d = 1'b0;
`ifdef DOT_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            ST_RUN: begin
                start_d = 1'b1;
                if (armed_q && dot_done) begin
                    // An armed done takes priority over a simultaneous expiry.
                    res_data_d  = dot_result;
                    res_valid_d = 1'b1;
                    start_d     = 1'b0;
                    armed_d     = 1'b0;
                    state_d     = ST_OUT;
                end else begin
                    // Done must be seen low once before it counts as fresh.
                    if (!dot_done) begin
                        armed_d = 1'b1;
                    end
`ifdef DOT_TIMEOUT_EN
                    if (cnt_q == CNT_LAST) begin
                        terr_d      = 1'b1;
                        res_data_d  = '0;
                        res_valid_d = 1'b1;
                        start_d     = 1'b0;
                        armed_d     = 1'b0;
                        state_d     = ST_OUT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`endif
                end
            end

            ST_OUT: begin
                start_d = 1'b0;
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_LOAD;
                end
            end

            default: begin
                state_d     = ST_LOAD;
                idx_d       = '0;
                armed_d     = 1'b0;
                start_d     = 1'b0;
                res_valid_d = 1'b0;
            end
        endcase

        // Registered so busy reflects the state being entered this edge.
        busy_d = !((state_d == ST_LOAD) && (idx_d == '0));
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            idx_q       <= '0;
            armed_q     <= 1'b0;
            start_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            armed_q     <= armed_d;
            start_q     <= start_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            busy_q      <= busy_d;
        end
    end

`ifdef DOT_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            terr_q <= terr_d;
        end
    end

    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Operand storage: one register pair per element, written only while the
    // write index points at it. Outside LOAD load_en is low, so the vectors
    // stay frozen for the dot stage.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < VECTOR_SIZE; gi++) begin : g_elem
        logic [BIT_WIDTH-1:0] a_elem_q, a_elem_d;
        logic [BIT_WIDTH-1:0] b_elem_q, b_elem_d;
        logic                 wr_en;

        always_comb begin
            wr_en    = load_en && (idx_q == IDX_W'(gi));
            a_elem_d = wr_en ? in_a : a_elem_q;
            b_elem_d = wr_en ? in_b : b_elem_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_elem_q <= '0;
                b_elem_q <= '0;
            end else begin
                a_elem_q <= a_elem_d;
                b_elem_q <= b_elem_d;
            end
        end

        assign a_vec[gi] = a_elem_q;
        assign b_vec[gi] = b_elem_q;
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready  = (state_q == ST_LOAD);
    assign start_dot = start_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dot_operand_loader.sv
module tb_dot_operand_loader;

    localparam int BW = 32;
    localparam int VS = 10;

    logic                   clk;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [BW-1:0]          in_a;
    logic [BW-1:0]          in_b;
    logic [VS-1:0][BW-1:0]  a_vec;
    logic [VS-1:0][BW-1:0]  b_vec;
    logic                   start_dot;
    logic [BW-1:0]          dot_result;
    logic                   dot_done;
    logic                   res_valid;
    logic                   res_ready;
    logic [BW-1:0]          res_data;
    logic                   busy;
    logic                   timeout_err;

    int checks = 0;
    int errors = 0;

    dot_operand_loader #(
        .FRACTION_WIDTH (15),
        .BIT_WIDTH      (BW),
        .VECTOR_SIZE    (VS),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .a_vec       (a_vec),
        .b_vec       (b_vec),
        .start_dot   (start_dot),
        .dot_result  (dot_result),
        .dot_done    (dot_done),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One load-phase cycle: inputs applied before the edge, expected
    // registered outputs observed after it.
    typedef struct {
        logic          v;
        logic [BW-1:0] a;
        logic [BW-1:0] b;
        logic          exp_busy;
        logic          exp_start;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_job(input logic [BW-1:0] base);
        for (int i = 0; i < VS; i++) begin
            in_valid = 1'b1;
            in_a     = base + BW'(i);
            in_b     = BW'(i);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        res_ready = 1'b1;
        dot_done  = 1'b0;
        tick();
        chk("drain_res_valid", {31'b0, res_valid}, 32'd0);
        chk("drain_in_ready", {31'b0, in_ready}, 32'd1);
        res_ready = 1'b0;
    endtask

    initial begin
        // Vector table: a = k*1.0 (Q15), b = 1.0, with in_valid gaps.
        tbl[0]  = '{1'b1, 32'h0000_0000, 32'h0000_8000, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 32'h0000_8000, 32'h0000_8000, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 32'h0001_0000, 32'h0000_8000, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 32'h0001_8000, 32'h0000_8000, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 32'h0002_0000, 32'h0000_8000, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 32'h0002_8000, 32'h0000_8000, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 32'h0003_0000, 32'h0000_8000, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 32'h0003_8000, 32'h0000_8000, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 32'h0004_0000, 32'h0000_8000, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 32'h0004_8000, 32'h0000_8000, 1'b1, 1'b1};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        dot_result = '0;
        dot_done   = 1'b0;
        res_ready  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_start", {31'b0, start_dot}, 32'd0);
        chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_timeout", {31'b0, timeout_err}, 32'd0);
        chk("rst_vec_zero", {31'b0, (|a_vec) | (|b_vec)}, 32'd0);

        // Test 1: async reset mid-LOAD after 4 pairs
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_a     = 32'hA0 + BW'(i);
            in_b     = 32'hB0 + BW'(i);
            tick();
        end
        in_valid = 1'b0;
        chk("t1_a3_loaded", a_vec[3], 32'hA3);
        chk("t1_busy_loading", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t1_async_vec_zero", {31'b0, (|a_vec) | (|b_vec)}, 32'd0);
        chk("t1_async_busy", {31'b0, busy}, 32'd0);
        chk("t1_async_in_ready", {31'b0, in_ready}, 32'd1);
        chk("t1_async_start", {31'b0, start_dot}, 32'd0);
        chk("t1_async_res_valid", {31'b0, res_valid}, 32'd0);
        #1;
        rst_n = 1'b1;

        // Test 2: table-driven load with gaps
        for (int i = 0; i < 14; i++) begin
            in_valid = tbl[i].v;
            in_a     = tbl[i].a;
            in_b     = tbl[i].b;
            chk($sformatf("t2_in_ready[%0d]", i), {31'b0, in_ready}, 32'd1);
            tick();
            chk($sformatf("t2_busy[%0d]", i), {31'b0, busy}, {31'b0, tbl[i].exp_busy});
            chk($sformatf("t2_start[%0d]", i), {31'b0, start_dot}, {31'b0, tbl[i].exp_start});
            if (i == 0) begin
                // Pre-reset data at index 1/3 must be gone; the pair went to 0.
                chk("t2_a1_cleared", a_vec[1], 32'd0);
                chk("t2_b0_first", b_vec[0], 32'h8000);
                chk("t2_b3_cleared", b_vec[3], 32'd0);
            end
        end
        in_valid = 1'b0;
        for (int k = 0; k < VS; k++) begin
            chk($sformatf("t2_a_vec[%0d]", k), a_vec[k], 32'h8000 * k);
            chk($sformatf("t2_b_vec[%0d]", k), b_vec[k], 32'h8000);
        end

        // Test 3: done after 3 low cycles, pairs offered but not consumed
        in_valid = 1'b1;
        in_a     = 32'h5555_5555;
        in_b     = 32'h6666_6666;
        dot_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t3_in_ready[%0d]", i), {31'b0, in_ready}, 32'd0);
            tick();
            chk($sformatf("t3_start[%0d]", i), {31'b0, start_dot}, 32'd1);
            chk($sformatf("t3_res_valid[%0d]", i), {31'b0, res_valid}, 32'd0);
        end
        dot_done   = 1'b1;
        dot_result = 32'h0016_8000;
        tick();
        chk("t3_res_valid", {31'b0, res_valid}, 32'd1);
        chk("t3_res_data", res_data, 32'h0016_8000);
        chk("t3_start_low", {31'b0, start_dot}, 32'd0);

        // Test 4: backpressure on result port
        dot_done   = 1'b0;
        dot_result = 32'hFFFF_FFFF;
        res_ready  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("t4_res_valid[%0d]", i), {31'b0, res_valid}, 32'd1);
            chk($sformatf("t4_res_data[%0d]", i), res_data, 32'h0016_8000);
            chk($sformatf("t4_in_ready[%0d]", i), {31'b0, in_ready}, 32'd0);
            chk($sformatf("t4_start[%0d]", i), {31'b0, start_dot}, 32'd0);
        end
        chk("t4_a0_untouched", a_vec[0], 32'd0);
        chk("t4_a9_untouched", a_vec[9], 32'h0004_8000);
        res_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t4_release_in_ready", {31'b0, in_ready}, 32'd1);
        chk("t4_release_res_valid", {31'b0, res_valid}, 32'd0);
        chk("t4_release_busy", {31'b0, busy}, 32'd0);
        // res_ready while nothing is valid: no effect
        tick();
        chk("t4_idle_ready_res_valid", {31'b0, res_valid}, 32'd0);
        chk("t4_idle_ready_in_ready", {31'b0, in_ready}, 32'd1);
        chk("t4_idle_ready_busy", {31'b0, busy}, 32'd0);
        res_ready = 1'b0;

        // Test 5: stale done on RUN entry is ignored
        dot_done = 1'b1;
        dot_result = 32'h0000_0099;
        load_job(32'h100);
        chk("t5_start", {31'b0, start_dot}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t5_stale_res_valid[%0d]", i), {31'b0, res_valid}, 32'd0);
            chk($sformatf("t5_stale_start[%0d]", i), {31'b0, start_dot}, 32'd1);
        end
        dot_done = 1'b0;
        tick();
        chk("t5_arm_res_valid", {31'b0, res_valid}, 32'd0);
        dot_done   = 1'b1;
        dot_result = 32'h0000_0042;
        tick();
        chk("t5_res_valid", {31'b0, res_valid}, 32'd1);
        chk("t5_res_data", res_data, 32'h0000_0042);
        chk("t5_start_low", {31'b0, start_dot}, 32'd0);
        chk("t5_a5", a_vec[5], 32'h105);
        chk("t5_b9", b_vec[9], 32'd9);
        drain();

`ifdef DOT_TIMEOUT_EN
        // Test 6: timeout with done stuck low
        dot_done = 1'b0;
        load_job(32'h200);
        repeat (15) tick();
        chk("t6_pre_res_valid", {31'b0, res_valid}, 32'd0);
        chk("t6_pre_start", {31'b0, start_dot}, 32'd1);
        chk("t6_pre_timeout", {31'b0, timeout_err}, 32'd0);
        tick();
        chk("t6_timeout", {31'b0, timeout_err}, 32'd1);
        chk("t6_res_valid", {31'b0, res_valid}, 32'd1);
        chk("t6_res_data", res_data, 32'd0);
        chk("t6_start", {31'b0, start_dot}, 32'd0);
        drain();
        load_job(32'h300);
        tick();
        dot_done   = 1'b1;
        dot_result = 32'h0000_0077;
        tick();
        chk("t6_next_res_data", res_data, 32'h0000_0077);
        chk("t6_sticky", {31'b0, timeout_err}, 32'd1);
        drain();
`else
        chk("no_timeout_err", {31'b0, timeout_err}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
